inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter DEPTH, 16, number of 32-bit instruction words held.
REQ-002 Parameter WIDTH, 32, instruction word width; fixed at 4 bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a new load at word 0.
REQ-006 in_valid  input  1  byte stream valid.
REQ-007 in_data  input  8  byte stream data.
REQ-008 in_last  input  1  marks final byte of the program; qualified by in_valid.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 busy  output  1  high in LOAD state.
REQ-011 done  output  1  high in DONE state.
REQ-012 word_count  output  5  number of words written since last start, 0..16.
REQ-013 rd_addr  input  4  fetch-side word address.
REQ-014 rd_data  output  32  fetch-side instruction word, registered.

Function
REQ-015 FSM states IDLE, LOAD, DONE; encoding free.
REQ-016 IDLE: start=1 -> LOAD; word_count, word pointer, byte index cleared to 0.
REQ-017 LOAD: in_ready=1 while word_count < DEPTH; byte accepted only on in_valid && in_ready.
REQ-018 Byte packing little-endian: byte index 0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-019 On acceptance of byte index 3: full word written to mem[pointer] same edge; pointer +1; word_count +1; byte index -> 0.
REQ-020 Accepted byte with in_last=1 at index < 3: partial word zero-padded in unfilled upper bytes, written that edge, word_count +1; FSM -> DONE.
REQ-021 Accepted byte with in_last=1 at index 3: normal word write; FSM -> DONE.
REQ-022 16th word written (word_count reaches DEPTH): FSM -> DONE regardless of in_last; in_ready low from next cycle.
REQ-023 DONE: in_ready=0; word_count holds; start=1 -> LOAD with clearing as REQ-016.
REQ-024 start during LOAD ignored; load continues.
REQ-025 in_valid with in_ready=0: byte not consumed, no state change; source must hold it.
REQ-026 No bytes accepted in IDLE or DONE.
REQ-027 Read port: rd_data <= mem[rd_addr] each rising edge; latency 1 cycle; active in all states.
REQ-028 Read and write to same address same edge: rd_data returns old contents.
REQ-029 Pointer width 4 bits; never wraps, since writes stop at DEPTH.

Reset
REQ-030 rst_n low asynchronously forces IDLE; in_ready=0, busy=0, done=0, word_count=0, rd_data=0, byte index and partial-word register 0.
REQ-031 Memory array contents not reset; words written before reset remain readable.
REQ-032 Reset mid-word discards the partial word; no write occurs.
REQ-033 After rst_n deasserts, no load begins until start pulses.

Verification
REQ-034 start; bytes 0x78,0x56,0x34,0x12 (last on 4th) -> mem[0]=0x12345678, word_count=1, done=1 cycle after last byte; rd_addr=0 -> rd_data=0x12345678 one cycle later.
REQ-035 start; bytes 0xAA,0xBB with last on 2nd -> mem[0]=0x0000BBAA, word_count=1, done=1.
REQ-036 start; 64 bytes with values 0..63, no in_last -> word_count=16, done=1, mem[15]=0x3F3E3D3C; byte 64 held valid -> in_ready=0, not consumed.
REQ-037 in_valid toggling 1,0,1,0 per cycle over 8 bytes -> only handshaked bytes packed; mem[0], mem[1] correct; start pulsed mid-load -> ignored.
REQ-038 rst_n low after 2 bytes of word 1 -> IDLE, word_count=0, mem[0] retains prior value, mem[1] unchanged; new start reloads from word 0.
REQ-039 Write mem[3] while rd_addr=3 same edge -> rd_data shows old value, new value on following cycle.

Source files
------------

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
// Packs an incoming byte stream (little-endian) into 32-bit instruction words
// and writes them into a small instruction memory. A separate fetch port reads
// the memory with one cycle of latency in every state.
//
// Ports
//   clk           : single clock, rising edge
//   rst_n         : asynchronous active-low reset
//   i_start       : one-cycle pulse, starts a new load at word 0 (IDLE/DONE only)
//   i_in_valid    : byte stream valid
//   i_in_data     : byte stream data
//   i_in_last     : final byte of the program, qualified by i_in_valid
//   o_in_ready    : a byte is accepted this cycle when i_in_valid is also high
//   o_busy        : high while loading
//   o_done        : high once the load has finished
//   o_word_count  : words written since the last start (0..DEPTH)
//   i_rd_addr     : fetch-side word address
//   o_rd_data     : fetch-side instruction word, registered
// ---------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_data,
    input  logic             i_in_last,
    output logic             o_in_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [4:0]       o_word_count,
    input  logic [3:0]       i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    // Count value at which the next word write fills the memory.
    localparam logic [4:0] LP_LAST = 5'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Instruction storage; intentionally not reset so a program survives rst_n.
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    state_t           r_state;
    logic [3:0]       r_ptr;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_partial;     // bytes 0..2 of the word being assembled
    logic [4:0]       r_word_count;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_accept;
    logic             w_word_end;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_data;

    assign w_accept   = i_in_valid && r_in_ready;
    assign w_word_end = (r_byte_idx == 2'd3) || i_in_last;
    assign w_wr_en    = w_accept && w_word_end;

    // Merge the incoming byte into the partial word; unfilled upper bytes are zero.
    always_comb begin
        w_wr_data = 32'd0;
        case (r_byte_idx)
            2'd0:    w_wr_data = {24'd0, i_in_data};
            2'd1:    w_wr_data = {16'd0, i_in_data, r_partial[7:0]};
            2'd2:    w_wr_data = {8'd0, i_in_data, r_partial[15:0]};
            2'd3:    w_wr_data = {i_in_data, r_partial[23:0]};
            default: w_wr_data = 32'd0;
        endcase
    end

    // Memory write port; a word is committed on the edge its final byte is accepted.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_ptr] <= w_wr_data;
        end
    end

    // Fetch port: registered read, so a same-edge write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 32'd0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    // Loader FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 4'd0;
            r_byte_idx   <= 2'd0;
            r_partial    <= 24'd0;
            r_word_count <= 5'd0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state      <= ST_LOAD;
                        r_ptr        <= 4'd0;
                        r_byte_idx   <= 2'd0;
                        r_partial    <= 24'd0;
                        r_word_count <= 5'd0;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // start is deliberately ignored here; the load runs to completion.
                    if (w_accept) begin
                        if (w_word_end) begin
                            r_ptr        <= r_ptr + 4'd1;
                            r_word_count <= r_word_count + 5'd1;
                            r_byte_idx   <= 2'd0;
                            r_partial    <= 24'd0;
                            // Finish on the program's last byte or when memory is full.
                            if (i_in_last || (r_word_count == LP_LAST)) begin
                                r_state    <= ST_DONE;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_partial  <= w_wr_data[23:0];
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_word_count = r_word_count;
    assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
// Self-checking bench: one task per scenario. A reference model of the
// memory is updated on each accepted byte; fetch-port expectations are
// pushed to a scoreboard queue when a read is issued and popped when the
// registered read data appears.
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_in_valid;
    logic [7:0]  i_in_data;
    logic        i_in_last;
    logic        o_in_ready;
    logic        o_busy;
    logic        o_done;
    logic [4:0]  o_word_count;
    logic [3:0]  i_rd_addr;
    logic [31:0] o_rd_data;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_mem [16];
    logic [31:0] m_word;
    int          m_idx;
    int          m_ptr;
    int          m_cnt;
    logic [31:0] sb_q [$];
    logic [31:0] exp_v;

    inst_mem_loader #(.DEPTH(16), .WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .i_in_last    (i_in_last),
        .o_in_ready   (o_in_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_word_count (o_word_count),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian packing model of one accepted byte.
    task automatic model_accept(input logic [7:0] d, input logic last);
        m_word[8*m_idx +: 8] = d;
        if (m_idx == 3 || last) begin
            m_mem[m_ptr] = m_word;
            m_ptr++;
            m_cnt++;
            m_idx  = 0;
            m_word = 32'd0;
        end else begin
            m_idx++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int t = 0;
        i_in_valid = 1'b1;
        i_in_data  = d;
        i_in_last  = last;
        while (!o_in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!o_in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1", o_in_ready);
        end else begin
            @(negedge clk);
            model_accept(d, last);
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_word = 32'd0;
    endtask

    // Drive a fetch address and queue its expected word; data appears after one edge.
    task automatic issue_read(input logic [3:0] a);
        i_rd_addr = a;
        sb_q.push_back(m_mem[a]);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests_run++; if (o_in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %0b want 0", o_in_ready); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0b want 0", o_busy); end
        tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %0b want 0", o_done); end
        tests_run++; if (o_word_count !== 5'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", o_word_count); end
        tests_run++; if (o_rd_data !== 32'd0) begin tests_failed++; $display("FAIL rst_rd_data: got %h want 0", o_rd_data); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Offered bytes must be ignored until start
        i_in_valid = 1'b1;
        i_in_data  = 8'h55;
        repeat (3) @(negedge clk);
        tests_run++; if (o_in_ready !== 1'b0 || o_busy !== 1'b0 || o_word_count !== 5'd0) begin
            tests_failed++; $display("FAIL idle_no_load: ready=%0b busy=%0b count=%0d want 0 0 0", o_in_ready, o_busy, o_word_count);
        end
        i_in_valid = 1'b0;
    endtask

    task automatic test_full_word();
        pulse_start();
        tests_run++; if (o_busy !== 1'b1 || o_in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL load_entry: busy=%0b ready=%0b want 1 1", o_busy, o_in_ready);
        end
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b1);
        tests_run++; if (o_done !== 1'b1 || o_word_count !== 5'd1 || o_in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL full_word_status: done=%0b count=%0d ready=%0b want 1 1 0", o_done, o_word_count, o_in_ready);
        end
        issue_read(4'd0);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h12345678) begin
            tests_failed++; $display("FAIL full_word_rd: got %h want 12345678 (model %h)", o_rd_data, exp_v);
        end
    endtask

    task automatic test_partial();
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        tests_run++; if (o_done !== 1'b1 || o_word_count !== 5'd1) begin
            tests_failed++; $display("FAIL partial_status: done=%0b count=%0d want 1 1", o_done, o_word_count);
        end
        issue_read(4'd0);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h0000BBAA) begin
            tests_failed++; $display("FAIL partial_rd: got %h want 0000bbaa (model %h)", o_rd_data, exp_v);
        end
    endtask

    task automatic test_fill();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i), 1'b0);
        end
        tests_run++; if (o_done !== 1'b1 || o_word_count !== 5'd16 || o_busy !== 1'b0) begin
            tests_failed++; $display("FAIL fill_status: done=%0b count=%0d busy=%0b want 1 16 0", o_done, o_word_count, o_busy);
        end
        // A 65th byte is offered and must not be consumed
        i_in_valid = 1'b1;
        i_in_data  = 8'h40;
        repeat (3) @(negedge clk);
        tests_run++; if (o_in_ready !== 1'b0 || o_word_count !== 5'd16) begin
            tests_failed++; $display("FAIL fill_hold: ready=%0b count=%0d want 0 16", o_in_ready, o_word_count);
        end
        i_in_valid = 1'b0;
        issue_read(4'd15);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h3F3E3D3C) begin
            tests_failed++; $display("FAIL fill_rd15: got %h want 3f3e3d3c (model %h)", o_rd_data, exp_v);
        end
        issue_read(4'd0);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h03020100) begin
            tests_failed++; $display("FAIL fill_rd0: got %h want 03020100 (model %h)", o_rd_data, exp_v);
        end
    endtask

    task automatic test_gaps_and_start();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h10 + 8'(i), 1'b0);
            // Idle cycle: junk data with valid low must not be packed
            i_in_data = 8'hFF;
            if (i == 4) i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end
        tests_run++; if (o_word_count !== 5'd2 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            tests_failed++; $display("FAIL gaps_status: count=%0d busy=%0b done=%0b want 2 1 0", o_word_count, o_busy, o_done);
        end
        issue_read(4'd0);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h13121110) begin
            tests_failed++; $display("FAIL gaps_rd0: got %h want 13121110 (model %h)", o_rd_data, exp_v);
        end
        issue_read(4'd1);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h17161514) begin
            tests_failed++; $display("FAIL gaps_rd1: got %h want 17161514 (model %h)", o_rd_data, exp_v);
        end
        send_byte(8'h99, 1'b1);
        issue_read(4'd2);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_done !== 1'b1 || o_word_count !== 5'd3) begin
            tests_failed++; $display("FAIL gaps_last: rd=%h done=%0b count=%0d want %h 1 3", o_rd_data, o_done, o_word_count, exp_v);
        end
    endtask

    task automatic test_reset_midword();
        pulse_start();
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        tests_run++; if (o_busy !== 1'b0 || o_in_ready !== 1'b0 || o_word_count !== 5'd0 || o_rd_data !== 32'd0) begin
            tests_failed++; $display("FAIL midrst_status: busy=%0b ready=%0b count=%0d rd=%h want 0 0 0 0", o_busy, o_in_ready, o_word_count, o_rd_data);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        m_idx  = 0;
        m_word = 32'd0;
        issue_read(4'd0);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL midrst_rd0: got %h want deadbeef (model %h)", o_rd_data, exp_v);
        end
        issue_read(4'd1);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h17161514) begin
            tests_failed++; $display("FAIL midrst_rd1: got %h want 17161514 (model %h)", o_rd_data, exp_v);
        end
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        issue_read(4'd0);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h04030201 || o_word_count !== 5'd1) begin
            tests_failed++; $display("FAIL midrst_reload: rd=%h count=%0d want 04030201 1", o_rd_data, o_word_count);
        end
    endtask

    task automatic test_rd_collision();
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            send_byte(8'h40 + 8'(i), 1'b0);
        end
        // Read and write of word 3 on the same edge
        i_rd_addr = 4'd3;
        sb_q.push_back(m_mem[3]);
        send_byte(8'h4F, 1'b1);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h0F0E0D0C) begin
            tests_failed++; $display("FAIL collide_old: got %h want 0f0e0d0c (model %h)", o_rd_data, exp_v);
        end
        issue_read(4'd3);
        exp_v = sb_q.pop_front();
        tests_run++; if (o_rd_data !== exp_v || o_rd_data !== 32'h4F4E4D4C) begin
            tests_failed++; $display("FAIL collide_new: got %h want 4f4e4d4c (model %h)", o_rd_data, exp_v);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        i_in_data  = 8'd0;
        i_in_last  = 1'b0;
        i_rd_addr  = 4'd0;
        m_word     = 32'd0;
        m_idx      = 0;
        m_ptr      = 0;
        m_cnt      = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
        test_reset();
        test_full_word();
        test_partial();
        test_fill();
        test_gaps_and_start();
        test_reset_midword();
        test_rd_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
